config_bus_writer: RTL and testbench

CONFIG_BUS_WRITER -- requirements
Module: config_bus_writer

---
 rtl/config_bus_writer_if.sv | 13 +
 rtl/config_bus_writer.sv | 180 ++++++++++++++++++
 tb/tb_config_bus_writer.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_bus_writer_if.sv
// Byte-stream receive handshake plus the register-bank write port of config_bus_writer.
// The slave modport is the writer's view; the master modport is the byte source / bank view.
interface config_bus_writer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wren;
    logic [2:0]  abus;
    logic [15:0] dbus;

    modport slave  (input rx_data, rx_valid, output rx_ready, wren, abus, dbus);
    modport master (output rx_data, rx_valid, input rx_ready, wren, abus, dbus);
endinterface

// File: rtl/config_bus_writer.sv
// Parses header/count/word-pairs/checksum frames, buffers up to 8 words, and bursts them into a register bank
// one cycle after the checksum edge; all outputs registered; rx_ready drops only while the burst drains.
module config_bus_writer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    config_bus_writer_if.slave        bus,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o
);
    typedef enum logic [2:0] {IDLE, CNT, DHI, DLO, CHK, COMMIT} state_e;

    state_e      state_q, state_d;
    logic [2:0]  start_q, start_d;
    logic [2:0]  nlast_q, nlast_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] tmo_q, tmo_d;
    logic        wren_q, wren_d;
    logic [2:0]  abus_q, abus_d;
    logic [15:0] dbus_q, dbus_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic        busy_q;
    logic        rx_ready_q;
    logic [15:0] wbuf_q [8];
    logic        wbuf_we;
    logic        acc;

    assign acc = bus.rx_valid & rx_ready_q;

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        nlast_d    = nlast_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        hi_d       = hi_q;
        tmo_d      = 16'd0;
        wren_d     = 1'b0;
        abus_d     = abus_q;
        dbus_d     = dbus_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wbuf_we    = 1'b0;
        case (state_q)
            IDLE: if (acc) begin
                if (bus.rx_data[7:3] == 5'b10100) begin
                    state_d = CNT;
                    start_d = bus.rx_data[2:0];
                    csum_d  = bus.rx_data;
                end else begin
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end
            end
            CNT: if (acc) begin
                if (bus.rx_data[7:3] == 5'b00000) begin
                    state_d = DHI;
                    nlast_d = bus.rx_data[2:0];
                    csum_d  = csum_q ^ bus.rx_data;
                    idx_d   = 4'd0;
                end else begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'b01;
                end
            end
            DHI: if (acc) begin
                hi_d    = bus.rx_data;
                csum_d  = csum_q ^ bus.rx_data;
                state_d = DLO;
            end
            DLO: if (acc) begin
                wbuf_we = 1'b1;
                csum_d  = csum_q ^ bus.rx_data;
                if (idx_q[2:0] == nlast_q) begin
                    state_d = CHK;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = DHI;
                end
            end
            CHK: if (acc) begin
                if (bus.rx_data == csum_q) begin
                    // First write goes out on the very edge after the checksum is accepted.
                    state_d = COMMIT;
                    wren_d  = 1'b1;
                    abus_d  = start_q;
                    dbus_d  = wbuf_q[0];
                    idx_d   = 4'd1;
                end else begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'b10;
                end
            end
            COMMIT: begin
                if (idx_q <= {1'b0, nlast_q}) begin
                    wren_d = 1'b1;
                    abus_d = start_q + idx_q[2:0];
                    dbus_d = wbuf_q[idx_q[2:0]];
                    idx_d  = idx_q + 4'd1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Idle timer only runs mid-frame; any accepted byte leaves tmo_d at its zero default.
        if ((state_q inside {CNT, DHI, DLO, CHK}) && !acc) begin
            if (tmo_q == TIMEOUT_CYC - 16'd1) begin
                state_d    = IDLE;
                err_d      = 1'b1;
                err_code_d = 2'b11;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            start_q    <= 3'd0;
            nlast_q    <= 3'd0;
            idx_q      <= 4'd0;
            csum_q     <= 8'd0;
            hi_q       <= 8'd0;
            tmo_q      <= 16'd0;
            wren_q     <= 1'b0;
            abus_q     <= 3'd0;
            dbus_q     <= 16'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            busy_q     <= 1'b0;
            rx_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            nlast_q    <= nlast_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            hi_q       <= hi_d;
            tmo_q      <= tmo_d;
            wren_q     <= wren_d;
            abus_q     <= abus_d;
            dbus_q     <= dbus_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= (state_d != IDLE);
            rx_ready_q <= (state_d != COMMIT);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wbuf_we) begin
            wbuf_q[idx_q[2:0]] <= {hi_q, bus.rx_data};
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.wren     = wren_q;
    assign bus.abus     = abus_q;
    assign bus.dbus     = dbus_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;
endmodule

// File: tb/tb_config_bus_writer.sv
// Scoreboarded bench for config_bus_writer: expected writes and done/err events are queued as frames are sent.
module tb_config_bus_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy, done, err;
    logic [1:0] err_code;

    config_bus_writer_if bus();

    config_bus_writer #(.TIMEOUT_CYC(16'd10)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .err_code_o (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       is_done;
        logic [1:0] code;
        logic [3:0] n;
    } ev_t;

    logic [18:0] wq[$];
    ev_t         evq[$];
    logic [7:0]  fr[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          err_cyc = 0;
    int          run = 0;
    int          wren_cnt = 0;
    int          done_cnt = 0;
    bit          wren_prev = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic exp_wr(input logic [2:0] a, input logic [15:0] d);
        wq.push_back({a, d});
    endtask

    task automatic exp_ev(input logic is_done, input logic [1:0] code, input logic [3:0] n);
        ev_t e;
        e.is_done = is_done;
        e.code    = code;
        e.n       = n;
        evq.push_back(e);
    endtask

    // Monitor: samples on the falling edge, pops the scoreboard on every write / done / err.
    always @(negedge clk) begin
        if (!rst_n) begin
            wren_prev = 1'b0;
        end else begin
            if (bus.wren) begin
                wren_cnt++;
                chk("wq_nonempty", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    logic [18:0] w;
                    w = wq.pop_front();
                    chk("abus", 32'(bus.abus), 32'(w[18:16]));
                    chk("dbus", 32'(bus.dbus), 32'(w[15:0]));
                end
                chk("rdy_in_commit", 32'(bus.rx_ready), 32'd0);
                run = wren_prev ? run + 1 : 1;
            end
            if (done || err) begin
                chk("done_err_excl", 32'(done & err), 32'd0);
                chk("evq_nonempty", 32'(evq.size() != 0), 32'd1);
                if (evq.size() != 0) begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("ev_kind", 32'(done), 32'(e.is_done));
                    if (done) begin
                        chk("burst_len", 32'(run), 32'(e.n));
                        chk("done_after_wren", 32'(wren_prev), 32'd1);
                    end else begin
                        chk("err_code", 32'(err_code), 32'(e.code));
                        err_cyc = cyc;
                    end
                end
                if (done) done_cnt++;
            end
            wren_prev = bus.wren;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_ready_wait", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_fr();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((wq.size() != 0 || evq.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_wq", 32'(wq.size()), 32'd0);
        chk("drain_ev", 32'(evq.size()), 32'd0);
    endtask

    // Builds a valid frame with random start/length/data and queues its expected writes.
    task automatic rand_frame();
        logic [2:0]  st;
        logic [3:0]  n;
        logic [7:0]  cs;
        logic [15:0] w;
        st = 3'($urandom_range(0, 7));
        n  = 4'($urandom_range(1, 8));
        fr = '{};
        fr.push_back({5'b10100, st});
        fr.push_back({5'b00000, 3'(n - 4'd1)});
        cs = fr[0] ^ fr[1];
        for (int i = 0; i < int'(n); i++) begin
            w = 16'($urandom);
            fr.push_back(w[15:8]);
            fr.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
            exp_wr(st + 3'(i), w);
        end
        fr.push_back(cs);
        exp_ev(1'b1, 2'b00, n);
    endtask

    initial begin
        int c0, seen, n, wc, dc;
        logic [7:0] cs;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({bus.rx_ready, bus.wren, bus.abus, busy, done, err, err_code}), 32'd0);
        chk("rst_dbus", 32'(bus.dbus), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 32'(bus.rx_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 32'(bus.rx_ready), 32'd1);

        // Single write.
        fr = '{8'hA2, 8'h00, 8'h12, 8'h34, 8'h84};
        exp_wr(3'd2, 16'h1234);
        exp_ev(1'b1, 2'b00, 4'd1);
        send_fr();
        drain();
        chk("busy_idle", 32'(busy), 32'd0);
        chk("abus_hold", 32'(bus.abus), 32'd2);
        chk("dbus_hold", 32'(bus.dbus), 32'h1234);

        // Wrapping three-word burst.
        fr = '{8'hA6, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'hA4};
        exp_wr(3'd6, 16'h1111);
        exp_wr(3'd7, 16'h2222);
        exp_wr(3'd0, 16'h3333);
        exp_ev(1'b1, 2'b00, 4'd3);
        send_fr();
        drain();

        // Bad checksum.
        fr = '{8'hA2, 8'h00, 8'h12, 8'h34, 8'h85};
        exp_ev(1'b0, 2'b10, 4'd0);
        send_fr();
        drain();
        @(negedge clk);
        chk("busy_after_badcs", 32'(busy), 32'd0);

        // Bad header, then bad count.
        fr = '{8'h55};
        exp_ev(1'b0, 2'b01, 4'd0);
        send_fr();
        drain();
        chk("busy_after_badhdr", 32'(busy), 32'd0);
        fr = '{8'hA0, 8'h08};
        exp_ev(1'b0, 2'b01, 4'd0);
        send_fr();
        drain();
        chk("busy_after_badcnt", 32'(busy), 32'd0);

        // Timeout after the count byte, then a normal frame.
        fr = '{8'hA1, 8'h01};
        send_fr();
        c0 = cyc;
        exp_ev(1'b0, 2'b11, 4'd0);
        drain();
        chk("tmo_latency", 32'(err_cyc - c0), 32'd10);
        chk("busy_after_tmo", 32'(busy), 32'd0);
        fr = '{8'hA2, 8'h00, 8'h12, 8'h34, 8'h84};
        exp_wr(3'd2, 16'h1234);
        exp_ev(1'b1, 2'b00, 4'd1);
        send_fr();
        drain();
        chk("err_code_hold", 32'(err_code), 32'd3);

        // Reset during the third write of an eight-word burst.
        fr = '{8'hA0, 8'h07};
        cs = 8'hA7;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] w;
            w = 16'hC000 + 16'(i * 16'h0111);
            fr.push_back(w[15:8]);
            fr.push_back(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
            exp_wr(3'(i), w);
        end
        fr.push_back(cs);
        send_fr();
        seen = 0;
        n = 0;
        while (seen < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.wren) seen++;
        end
        chk("third_wren_seen", 32'(seen), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("wren_async_drop", 32'(bus.wren), 32'd0);
        wq.delete();
        wc = wren_cnt;
        dc = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_wren_after_rst", 32'(wren_cnt - wc), 32'd0);
        chk("no_done_after_rst", 32'(done_cnt - dc), 32'd0);

        // A few random well-formed frames.
        for (int k = 0; k < 6; k++) begin
            rand_frame();
            send_fr();
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
